// File: rtl/vector_mem_responder.sv
// vector_mem_responder
// Memory-side responder for the 16-lane vector core's data port. Accepts one
// whole-vector load or store at a time and serialises it over a single-ported
// 32-bit synchronous word RAM, one lane per cycle.
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both 1. req_ready is high only in IDLE (and never during rst);
// requests seen while busy are ignored, so the core must hold req_valid.
// resp_valid is a one-cycle pulse; busy covers acceptance through that pulse.
//
// Optional feature: define VMEM_SCALAR_ACCESS_EN to add the req_scalar input,
// which restricts a request to the scalar lane (LANES-1) at word addr.
// dbgState exposes the FSM state for observation.
module vector_mem_responder #(
    parameter int LANES  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 21,
    parameter int DEPTH  = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              addr,
    input  logic                           mem_write,
    input  logic [LANES-1:0][DATA_W-1:0]   data_write,
`ifdef VMEM_SCALAR_ACCESS_EN
    input  logic                           req_scalar,
`endif
    output logic [LANES-1:0][DATA_W-1:0]   data_read,
    output logic                           resp_valid,
    output logic                           busy,
    output logic [2:0]                     dbgState
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LANES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD     = 3'd2,
        RDLAST = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                          state;
    logic [CNT_W-1:0]                cnt;
    logic [IDX_W-1:0]                baseIdx;
    logic                            isScalar;
    logic [LANES-1:0][DATA_W-1:0]    wrVec;
    logic [LANES-1:0][DATA_W-1:0]    shadow;

    logic [DATA_W-1:0]               mem [DEPTH];
    logic [DATA_W-1:0]               rdData;
    logic [IDX_W-1:0]                ramAddr;
    logic                            ramWe;
    logic [DATA_W-1:0]               ramWdata;
    logic                            lastLane;
    logic                            unusedAddrHi;

    // Address bits above the RAM index are deliberately ignored.
    assign unusedAddrHi = ^addr[ADDR_W-1:IDX_W];

    // Lane k lives at (base + k) mod DEPTH; the IDX_W-bit add wraps naturally.
    assign ramAddr  = baseIdx + IDX_W'(cnt);
    // Reset must suppress the in-flight write so an aborted store stops at once.
    assign ramWe    = (state == WR) && !rst;
    assign ramWdata = isScalar ? wrVec[LANES-1] : wrVec[cnt];
    assign lastLane = isScalar || (cnt == CNT_W'(LANES - 1));

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) && !rst;
    assign dbgState  = state;

`ifndef VMEM_SCALAR_ACCESS_EN
    assign isScalar = 1'b0;
`endif

    // Single-ported synchronous RAM: read-first, contents survive reset.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            mem[ramAddr] <= ramWdata;
        end
        rdData <= mem[ramAddr];
    end

    // Request FSM: capture, serialise lanes, assemble the load vector, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            data_read  <= '0;
`ifdef VMEM_SCALAR_ACCESS_EN
            isScalar   <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        baseIdx <= addr[IDX_W-1:0];
                        wrVec   <= data_write;
`ifdef VMEM_SCALAR_ACCESS_EN
                        isScalar <= req_scalar;
`endif
                        cnt     <= '0;
                        state   <= mem_write ? WR : RD;
                    end
                end
                WR: begin
                    cnt <= cnt + 1'b1;
                    if (lastLane) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RD: begin
                    // The read issued on the previous edge is now in rdData.
                    if (cnt != '0) begin
                        shadow[cnt - 1'b1] <= rdData;
                    end
                    cnt <= cnt + 1'b1;
                    if (lastLane) begin
                        state <= RDLAST;
                    end
                end
                RDLAST: begin
                    // Whole vector lands in one edge so the core never sees a
                    // partially updated data_read.
                    shadow[LANES-1] <= rdData;
                    if (isScalar) begin
                        data_read <= '0;
                    end else begin
                        data_read <= shadow;
                    end
                    data_read[LANES-1] <= rdData;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_responder.sv
// Bench for vector_mem_responder: directed requests, a behavioural memory /
// latency model, a per-cycle compare process and literal lane checks.
`timescale 1ns/1ps
module tb_vector_mem_responder;

    localparam int LANES  = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 21;
    localparam int DEPTH  = 4096;

    typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] addr = '0;
    logic              mem_write = 1'b0;
    vec_t              data_write = '0;
    vec_t              data_read;
    logic              resp_valid;
    logic              busy;
    logic [2:0]        dbgState;
`ifdef VMEM_SCALAR_ACCESS_EN
    logic              req_scalar = 1'b0;
`endif

    always #5 clk = ~clk;

    vector_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .addr       (addr),
        .mem_write  (mem_write),
        .data_write (data_write),
`ifdef VMEM_SCALAR_ACCESS_EN
        .req_scalar (req_scalar),
`endif
        .data_read  (data_read),
        .resp_valid (resp_valid),
        .busy       (busy),
        .dbgState   (dbgState)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] modelMem [DEPTH];
    vec_t              expQ[$];
    vec_t              modelRead;
    int                cyc = 0;
    int                c0 = -100;
    int                respCyc = -100;
    bit                active = 0;
    bit                pendStore = 0;
    bit                pendLoad = 0;
    bit                pendScalar = 0;
    int                pendBase = 0;
    vec_t              pendData;
    bit                chkEn = 0;

    task automatic check1(input string name, input logic act, input logic expV);
        checks++;
        if (act !== expV) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, expV);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int expV);
        checks++;
        if (act !== expV) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expV);
        end
    endtask

    task automatic checkVec(input string name, input vec_t act, input vec_t expV);
        checks++;
        if (act !== expV) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expV);
        end
    endtask

    task automatic checkLanes(input string name, input vec_t expV);
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if (data_read[k] !== expV[k]) begin
                failures++;
                $display("FAIL %s lane %0d: got %h expected %h", name, k, data_read[k], expV[k]);
            end
        end
    endtask

    // Model update on each edge, then compare every cycle once outputs settle.
    initial begin : modelAndCompare
        int  n;
        bit  expBusy;
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        modelRead = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                if (active && pendStore && cyc > c0) begin
                    n = cyc - c0 - 1;
                    if (n > LANES) n = LANES;
                    if (pendScalar && n > 0) modelMem[pendBase] = pendData[LANES-1];
                    else for (int k = 0; k < n; k++) modelMem[(pendBase + k) % DEPTH] = pendData[k];
                end
                active    = 0;
                pendStore = 0;
                pendLoad  = 0;
                expQ.delete();
                modelRead = '0;
                chkEn     = 1;
            end else if (active && cyc == respCyc) begin
                if (pendStore) begin
                    if (pendScalar) modelMem[pendBase] = pendData[LANES-1];
                    else for (int k = 0; k < LANES; k++) modelMem[(pendBase + k) % DEPTH] = pendData[k];
                end
                if (pendLoad && expQ.size() > 0) modelRead = expQ.pop_front();
                pendStore = 0;
                pendLoad  = 0;
            end
            #2;
            if (chkEn) begin
                expBusy = active && (cyc >= c0) && (cyc <= respCyc);
                check1("resp_valid", resp_valid, active && (cyc == respCyc));
                check1("busy", busy, expBusy);
                check1("req_ready", req_ready, !expBusy && !rst);
                checkVec("data_read", data_read, modelRead);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic vec_t randVec();
        vec_t v;
        for (int k = 0; k < LANES; k++) v[k] = $urandom;
        return v;
    endfunction

    // Presents a request (holding it while busy) and registers it with the
    // model the cycle it will be accepted; scrambles the inputs after E0.
    task automatic startReq(input logic [ADDR_W-1:0] a, input logic w, input vec_t d, input logic sc);
        bit   got;
        vec_t e;
        int   base;
        got = 0;
        for (int t = 0; t < 60 && !got; t++) begin
            if (t > 0) @(negedge clk);
            req_valid  = 1'b1;
            addr       = a;
            mem_write  = w;
            data_write = d;
`ifdef VMEM_SCALAR_ACCESS_EN
            req_scalar = sc;
`endif
            #1;
            if (req_ready === 1'b1) begin
                got        = 1;
                base       = int'(a) % DEPTH;
                c0         = cyc + 1;
                active     = 1;
                pendBase   = base;
                pendData   = d;
                pendScalar = sc;
                pendStore  = w;
                pendLoad   = !w;
                respCyc    = c0 + (sc ? (w ? 2 : 3) : (w ? 17 : 18)) - 1;
                if (!w) begin
                    e = '0;
                    if (sc) e[LANES-1] = modelMem[base];
                    else for (int k = 0; k < LANES; k++) e[k] = modelMem[(base + k) % DEPTH];
                    expQ.push_back(e);
                end
            end
        end
        if (!got) begin
            checkInt("accept_timeout", 0, 1);
        end else begin
            @(negedge clk);
            req_valid  = 1'b0;
            addr       = ADDR_W'($urandom);
            mem_write  = 1'($urandom_range(0, 1));
            data_write = randVec();
`ifdef VMEM_SCALAR_ACCESS_EN
            req_scalar = 1'($urandom_range(0, 1));
`endif
        end
    endtask

    // Waits for resp_valid; latency counts the handshake cycle as cycle 0.
    task automatic waitResp(output int lat);
        lat = -1;
        for (int t = 0; t < 40 && lat < 0; t++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) lat = cyc - c0 + 1;
        end
        if (lat < 0) checkInt("resp_timeout", 0, 1);
    endtask

    task automatic doReq(input logic [ADDR_W-1:0] a, input logic w, input vec_t d, input logic sc, output int lat);
        startReq(a, w, d, sc);
        waitResp(lat);
    endtask

    // ---------------- directed tests ----------------
    initial begin : stimulus
        int   lat;
        int   r1;
        int   respSeen;
        vec_t v;
        vec_t e;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check1("rst_req_ready", req_ready, 1'b0);
        rst = 1'b0;
        #1;
        check1("post_rst_req_ready", req_ready, 1'b1);
        check1("post_rst_busy", busy, 1'b0);
        check1("post_rst_resp", resp_valid, 1'b0);
        checkVec("post_rst_data", data_read, '0);
        @(negedge clk);

        // Known-zero regions used below
        doReq(21'h000, 1'b1, '0, 1'b0, lat);
        doReq(21'h040, 1'b1, '0, 1'b0, lat);
        doReq(21'h100, 1'b1, '0, 1'b0, lat);

        // Store then load at 0x010
        for (int k = 0; k < LANES; k++) v[k] = 32'hA000_0000 + 32'(k);
        doReq(21'h010, 1'b1, v, 1'b0, lat);
        checkInt("store_latency", lat, 17);
        doReq(21'h010, 1'b0, randVec(), 1'b0, lat);
        checkInt("load_latency", lat, 18);
        checkLanes("load_0x010", v);

        // Wrap-around at the top of the RAM
        for (int k = 0; k < LANES; k++) v[k] = 32'(k + 1);
        doReq(21'd4092, 1'b1, v, 1'b0, lat);
        doReq(21'h000, 1'b0, '0, 1'b0, lat);
        for (int k = 0; k < LANES; k++) e[k] = (k < 12) ? 32'(k + 5) : 32'h0;
        checkLanes("wrap_load_0", e);
        doReq(21'd4092, 1'b0, '0, 1'b0, lat);
        for (int k = 0; k < LANES; k++) e[k] = 32'(k + 1);
        checkLanes("wrap_load_4092", e);

        // Request held while busy is accepted right after RESP
        startReq(21'h200, 1'b1, randVec(), 1'b0);
        r1 = respCyc;
        startReq(21'h010, 1'b0, '0, 1'b0);
        checkInt("accept_after_resp", c0, r1 + 2);
        waitResp(lat);
        checkInt("held_load_latency", lat, 18);
        for (int k = 0; k < LANES; k++) e[k] = 32'hA000_0000 + 32'(k);
        checkLanes("held_load", e);

        // Reset in the middle of a store at 0x100
        for (int k = 0; k < LANES; k++) v[k] = 32'hFFFF_FFFF;
        startReq(21'h100, 1'b1, v, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkVec("abort_data_read", data_read, '0);
        respSeen = 0;
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) respSeen++;
        end
        checkInt("abort_no_resp", respSeen, 0);
        doReq(21'h100, 1'b0, '0, 1'b0, lat);
        for (int k = 0; k < LANES; k++) e[k] = (k < 6) ? 32'hFFFF_FFFF : 32'h0;
        checkLanes("abort_load", e);

        // Address bits above the RAM index are ignored
        for (int k = 0; k < LANES; k++) v[k] = 32'h5A00_0000 + 32'(k * 32'h1111);
        doReq(21'h1_0020, 1'b1, v, 1'b0, lat);
        doReq(21'h0_0020, 1'b0, '0, 1'b0, lat);
        checkVec("high_bits_vec", data_read, v);

`ifdef VMEM_SCALAR_ACCESS_EN
        // Scalar lane access
        v = randVec();
        v[LANES-1] = 32'hDEAD_BEEF;
        doReq(21'h040, 1'b1, v, 1'b1, lat);
        checkInt("scalar_store_latency", lat, 2);
        doReq(21'h040, 1'b0, randVec(), 1'b1, lat);
        checkInt("scalar_load_latency", lat, 3);
        e = '0;
        e[LANES-1] = 32'hDEAD_BEEF;
        checkLanes("scalar_load", e);
        doReq(21'h040, 1'b0, '0, 1'b0, lat);
        e = '0;
        e[0] = 32'hDEAD_BEEF;
        checkLanes("scalar_vector_load", e);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vector_mem_responder.md
Name: vector_mem_responder

Overview:
- Memory-side responder for the 16-lane vector core's data port; the other end of the core's addr / dataWrite / memWrite / dataRead interface.
- Accepts one whole-vector load or store request at a time.
- Serialises the request over a single-ported, 32-bit-wide synchronous word RAM, one lane per cycle.
- Returns a full vector to the core, with a valid/ready handshake and a busy indication the pipeline uses as a stall.

Parameters:
- LANES, 16, number of 32-bit lanes per vector (core fixes 16).
- DATA_W, 32, lane width in bits.
- ADDR_W, 21, request address width (matches core addr).
- DEPTH, 4096, RAM depth in words, power of two; index = low log2(DEPTH) bits.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- addr  input  ADDR_W  base word address of the vector.
- mem_write  input  1  1 = store, 0 = load; sampled with request.
- data_write  input  LANES x DATA_W  store vector; lane k is data_write[k].
- data_read  output  LANES x DATA_W  load result vector; lane k is data_read[k].
- resp_valid  output  1  one-cycle pulse: request complete.
- busy  output  1  high from acceptance until the resp_valid cycle, inclusive.

Behaviour:
- Reset values: req_ready=0 during rst, 1 the cycle after; resp_valid=0, busy=0, data_read=all zero. FSM goes to IDLE and lane counter to 0. RAM contents are not cleared.
- Acceptance: handshake at the rising edge where req_valid and req_ready are both 1 (edge E0). addr, mem_write and data_write are captured into internal registers at E0. The core may change these inputs after E0.
- Lane addressing: lane k uses word index (addr + k) mod DEPTH, for k = 0..LANES-1. Wrap-around past DEPTH-1 goes to 0. addr bits above log2(DEPTH) are ignored.
- FSM states: IDLE, WR, RD, RDLAST, RESP.
  - IDLE: req_ready=1. On handshake, go to WR if mem_write=1, else RD; counter cleared.
  - WR: at each edge E1..E16, write captured lane cnt to RAM and increment cnt. After the lane-15 write, go to RESP.
  - RD: RAM read address = base+cnt. At edges E1..E16, issue the read for lane cnt. At edges E2..E16, latch the previous lane's data into a shadow vector. After issuing lane 15, go to RDLAST.
  - RDLAST: at E17, latch lane 15 and copy the whole shadow vector into data_read in the same edge. data_read therefore never shows a partial vector. Go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0. Next state is IDLE.
- Latency, counted in cycles after E0 (the resp_valid cycle):
  - store: resp_valid high in the cycle after E16; 17 cycles total.
  - load: resp_valid high in the cycle after E17; 18 cycles total.
- data_read holds its value until the next load completes. Stores never alter data_read.
- busy = (state != IDLE). req_ready = (state == IDLE) and not rst.
- Requests presented while busy are ignored and not queued; the core must hold req_valid.
- A new request can be accepted in the cycle after RESP. Maximum throughput is one request per 18 (store) or 19 (load) cycles.
- Reset mid-operation: abort immediately and go to IDLE, counter to 0, resp_valid=0.
  - Lanes already written stay in RAM; remaining lanes are not written.
  - An aborted load leaves data_read at zero, because reset clears it.
- Read-after-write ordering: a load accepted after a store's RESP observes all 16 stored lanes.

Optional Feature:
- Macro VMEM_SCALAR_ACCESS_EN.
- Defined: adds input port req_scalar (1 bit), captured at E0.
  - When req_scalar=1, only lane LANES-1 (the scalar lane) is accessed, at word index addr mod DEPTH.
  - Scalar store: one write at E1, resp_valid in the cycle after E1.
  - Scalar load: read issued at E1; at E2, data_read[LANES-1] is updated and all other lanes are zeroed; resp_valid in the cycle after E2.
- Not defined: port absent; every request is a full-vector access as above.

Test Plan:
- Store then load at base 0x010, data_write[k]=0xA000_0000+k → store resp_valid exactly 17 cycles after E0. Load resp_valid exactly 18 cycles after E0, with data_read[k]=0xA000_0000+k for every k.
- Wrap: store at addr=DEPTH-4 (4092) with lane k=k+1, then load at addr=0 → data_read[0..11]=5..16. A load at 4092 returns 1..16.
- Busy ignore: hold req_valid with a different addr during a store → req_ready=0 and busy=1 throughout. The second request is accepted on the first cycle after RESP.
- Reset mid-store: assert rst after E6 (lanes 0..5 written) at base 0x100, all lanes 0xFFFF_FFFF over RAM pre-loaded with 0 → resp_valid never asserts. A subsequent load returns 0xFFFF_FFFF in lanes 0..5 and 0 in lanes 6..15.
- Address high bits: store at addr=0x1_0020 and load at addr=0x0020 (DEPTH=4096) → identical vectors read back.
- VMEM_SCALAR_ACCESS_EN defined, scalar store 0xDEAD_BEEF at 0x040, then scalar load → store resp 2 cycles after E0, load resp 3 cycles after E0. data_read[15]=0xDEAD_BEEF and lanes 0..14 zero; a vector load at 0x040 shows 0xDEAD_BEEF only in lane 0.
